// File: rtl/ysyx_24100006_pipe_fifo.sv
// Pipeline skid FIFO between stages: circular buffer with registered
// occupancy and optional same-cycle pass-through when full.
module ysyx_24100006_pipe_fifo #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 2,
  parameter bit REG_READY = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush_i,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_q, wr_d;
  logic [PW-1:0]     rd_q, rd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              full;
  logic              accept;
  logic              send;

  assign full      = (cnt_q == CW'(DEPTH));
  assign out_valid = (cnt_q != '0);
  assign out_data  = mem_q[rd_q];
  assign count_o   = cnt_q;

  // When full, ready may follow out_ready: the head slot frees this edge
  if (REG_READY) begin : g_reg_rdy
    assign in_ready = ~full;
  end else begin : g_comb_rdy
    assign in_ready = ~full | out_ready;
  end

  assign accept = in_valid & in_ready;
  assign send   = out_valid & out_ready;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (accept) wr_d = wr_q + PW'(1);
      if (send)   rd_d = rd_q + PW'(1);
      unique case ({accept, send})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && !flush_i) begin
      mem_q[wr_q] <= in_data;
    end
  end

endmodule
